instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage between the program counter and decode.
- Takes the current pc, issues one instruction-memory request at a time over a valid/ready handshake, and accepts variable-latency responses.
- Holds the fetched instruction in the IF/ID register.
- Drives stall_pc back to the program counter; honours decode back-pressure (stall_id) and redirect (flush).

Parameters:
- ADDR_WIDTH, 32, width of pc and memory address.
- NOP_INSTR, 32'h00000013, instruction injected on a misaligned pc (addi x0,x0,0).

Ports:
- clk input 1 — clock, all state on posedge.
- reset input 1 — synchronous, active-low; clears state on a posedge where reset==0.
- pc input ADDR_WIDTH — current pc from program_counter.
- flush input 1 — redirect taken (jump/branch); kills the in-flight fetch and the IF/ID contents.
- stall_id input 1 — decode cannot accept; IF/ID must hold.
- stall_pc output 1 — to program_counter; 1 blocks the pc update.
- imem_req_valid output 1 — memory request valid.
- imem_req_ready input 1 — memory accepts request.
- imem_req_addr output ADDR_WIDTH — request address, word-aligned.
- imem_rsp_valid input 1 — response data valid (one-cycle pulse, no back-pressure).
- imem_rsp_data input 32 — instruction word.
- if_valid output 1 — IF/ID holds a live instruction.
- if_pc output ADDR_WIDTH — pc of the IF/ID instruction.
- if_instr output 32 — instruction.
- if_pc_plus4 output ADDR_WIDTH — if_pc+4 (pc_increment source).
- if_misaligned output 1 — IF/ID entry came from pc[1:0]!=0.

Behaviour:
- Reset values:
  - State IDLE; drop=0; skid empty.
  - if_valid=0; if_pc, if_instr, if_pc_plus4, if_misaligned = 0.
  - imem_req_valid=0; stall_pc=1.
- "advance" = the cycle in which a word, or a misaligned NOP, is written into IF/ID.
- stall_pc = ~(advance | flush). The pc updates exactly once per delivered instruction, and always on a redirect.
- At most one outstanding memory request.
- Slot free = ~if_valid | ~stall_id.
- States:
  - IDLE: entered only from reset; goes to REQ on the next cycle.
  - REQ:
    - pc[1:0]!=0 and slot free: no request; load IF/ID with {pc, NOP_INSTR, misaligned=1}; advance; stay in REQ.
    - pc[1:0]!=0 and slot not free: no request; stay in REQ.
    - pc aligned: imem_req_valid=1, imem_req_addr = pc with bits [1:0] forced to 0. On imem_req_ready, capture req_pc=pc and go to WAIT.
    - imem_req_valid and imem_req_addr stay stable until ready. The pc cannot change here except by flush.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid with drop=1: discard, clear drop, go to REQ.
    - On imem_rsp_valid, drop=0, slot free: load IF/ID {req_pc, rsp_data, 0}; advance; go to REQ.
    - On imem_rsp_valid, drop=0, slot not free: store in the skid register; go to HOLD.
  - HOLD: when slot is free, move the skid into IF/ID; advance; go to REQ.
- IF/ID when not loaded:
  - If stall_id=1, hold all if_* outputs.
  - If stall_id=0, clear if_valid.
- Flush (highest priority, same cycle as any event):
  - if_valid goes to 0 next cycle; the skid is emptied.
  - REQ: go to WAIT with drop=1 if the handshake completed this cycle; otherwise stay in REQ.
  - WAIT: set drop=1. If imem_rsp_valid is also high this cycle, discard the response and go to REQ with drop=0.
  - HOLD: discard the skid; go to REQ.
  - IDLE: no effect.
- Flush and stall_id in the same cycle: flush wins, IF/ID is cleared.
- reset low mid-request: state returns to IDLE. A memory response arriving after reset release while in IDLE/REQ is ignored.
- Latency with a 1-cycle memory: request cycle, then response cycle. Throughput is one instruction per 2 cycles; if_valid rises the cycle after the response.
- if_pc_plus4 wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package holds:
  - Fetch state encoding: IDLE, REQ, WAIT, HOLD.
  - NOP_INSTR constant.
  - BRANCH opcode 7'b1100011, already used by pc_mux.
- One natural sub-module, if_id_reg: the IF/ID register with load/hold/clear and the if_pc_plus4 adder.
- The FSM, drop flag and skid stay in instruction_fetch.

Test Plan:
- Reset low 2 cycles, then release, pc=0x0, 1-cycle memory returns 0x00500093 -> imem_req_addr=0x0 the cycle after IDLE; if_valid=1, if_instr=0x00500093, if_pc=0x0, if_pc_plus4=0x4; stall_pc=0 exactly in the response cycle.
- imem_req_ready held low 3 cycles with pc=0x8 -> imem_req_valid stays 1, addr stays 0x8, stall_pc=1 throughout.
- Response for pc=0x10 while stall_id=1 and if_valid=1 -> data goes to the skid, IF/ID unchanged; when stall_id drops, next cycle if_pc=0x10, and stall_pc=0 for exactly one cycle.
- Flush during WAIT for pc=0x20, then response 0xDEADBEEF 2 cycles later, new pc=0x100 -> 0xDEADBEEF never appears on if_instr; next request addr=0x100.
- Flush in the same cycle as imem_rsp_valid -> response dropped, if_valid=0 next cycle, state REQ.
- pc=0x6 -> no imem_req_valid; if_instr=0x00000013, if_misaligned=1, if_pc=0x6.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, injected NOP and opcode constants.
package instruction_fetch_pkg;

    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load, hold under decode stall, clear on flush or drain.
module if_id_reg #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic                  stall_id_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [31:0]           instr_i,
    input  logic                  misaligned_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  misaligned_o
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           instr_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_q;
    logic                  misaligned_q;

    // Flush outranks load; an unloaded, unstalled entry is consumed by decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            instr_q      <= '0;
            pc_plus4_q   <= '0;
            misaligned_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q      <= 1'b1;
            pc_q         <= pc_i;
            instr_q      <= instr_i;
            pc_plus4_q   <= pc_i + ADDR_WIDTH'(4);
            misaligned_q <= misaligned_i;
        end else if (!stall_id_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o      = valid_q;
    assign pc_o         = pc_q;
    assign instr_o      = instr_q;
    assign pc_plus4_o   = pc_plus4_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, response skid, flush-drop tracking,
// and pc stall generation feeding the IF/ID register.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = instruction_fetch_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    input  logic                  stall_id,
    output logic                  stall_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [31:0]           if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc_plus4,
    output logic                  if_misaligned
);

    import instruction_fetch_pkg::*;

    fetch_state_e          state_q, state_d;
    logic                  drop_q, drop_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]           skid_instr_q, skid_instr_d;

    logic                  slot_free_c;
    logic                  req_valid_c;
    logic                  load_c;
    logic [ADDR_WIDTH-1:0] load_pc_c;
    logic [31:0]           load_instr_c;
    logic                  load_mis_c;

    assign slot_free_c = ~if_valid | ~stall_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            drop_q       <= 1'b0;
            req_pc_q     <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            req_pc_q     <= req_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // Next state, request and IF/ID load selection; flush takes priority everywhere.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        req_pc_d     = req_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        req_valid_c  = 1'b0;
        load_c       = 1'b0;
        load_pc_c    = req_pc_q;
        load_instr_c = imem_rsp_data;
        load_mis_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (is_misaligned(pc[1:0])) begin
                    if (slot_free_c && !flush) begin
                        load_c       = 1'b1;
                        load_pc_c    = pc;
                        load_instr_c = NOP_INSTR;
                        load_mis_c   = 1'b1;
                    end
                end else begin
                    req_valid_c = 1'b1;
                    if (imem_req_ready) begin
                        req_pc_d = pc;
                        drop_d   = flush;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (slot_free_c) begin
                        load_c  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = imem_rsp_data;
                        state_d      = ST_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_REQ;
                end else if (slot_free_c) begin
                    load_c       = 1'b1;
                    load_pc_c    = skid_pc_q;
                    load_instr_c = skid_instr_q;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset masks the handshake and holds the pc.
    assign imem_req_valid = reset & req_valid_c;
    assign imem_req_addr  = {pc[ADDR_WIDTH-1:2], 2'b00};
    assign stall_pc       = ~reset | ~(load_c | flush);

    if_id_reg #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_c),
        .flush_i     (flush),
        .stall_id_i  (stall_id),
        .pc_i        (load_pc_c),
        .instr_i     (load_instr_c),
        .misaligned_i(load_mis_c),
        .valid_o     (if_valid),
        .pc_o        (if_pc),
        .instr_o     (if_instr),
        .pc_plus4_o  (if_pc_plus4),
        .misaligned_o(if_misaligned)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle vector table, hand-written skid/flush sequence,
// and a randomized run checked against an in-order instruction-stream model.
module tb_instruction_fetch;

    localparam int unsigned AW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int unsigned N   = 48;

    logic          clk;
    logic          reset;
    logic [AW-1:0] pc;
    logic          flush;
    logic          stall_id;
    logic          stall_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc_plus4;
    logic          if_misaligned;

    instruction_fetch #(.ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .flush         (flush),
        .stall_id      (stall_id),
        .stall_pc      (stall_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_pc_plus4   (if_pc_plus4),
        .if_misaligned (if_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        fl;
        logic        sid;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_stall;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic [31:0] p, input logic f, input logic s,
                       input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic es, input logic erv, input logic [31:0] ea,
                       input logic eiv, input logic [31:0] epc, input logic [31:0] ein,
                       input logic [31:0] ep4, input logic em);
        vec_t v;
        v.rst = r; v.pc = p; v.fl = f; v.sid = s; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_stall = es; v.e_rv = erv; v.e_addr = ea; v.e_ifv = eiv;
        v.e_ifpc = epc; v.e_instr = ein; v.e_p4 = ep4; v.e_mis = em;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic [31:0] p, input logic f, input logic s,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        reset = r; pc = p; flush = f; stall_id = s;
        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    logic [31:0] plist[N+4];
    logic [31:0] tmp;
    logic [31:0] e_instr;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          k;
    int          c;

    initial begin
        reset = 1'b0; pc = '0; flush = 1'b0; stall_id = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        //   rst pc           fl sid rdy rv rd            stall rv addr          ifv ifpc         instr         p4           mis
        row(0, 32'h0,        0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h0,        0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h0,        0, 0, 1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h0,        0, 0, 0, 1, 32'h00500093,  0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h8,        0, 0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0,        32'h00500093, 32'h4,       0);
        row(1, 32'h8,        0, 0, 0, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0,        32'h00500093, 32'h4,       0);
        row(1, 32'h8,        0, 0, 0, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0,        32'h00500093, 32'h4,       0);
        row(1, 32'h8,        0, 0, 1, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0,        32'h00500093, 32'h4,       0);
        row(1, 32'h8,        0, 0, 0, 1, 32'h11111111,  0, 0, 32'h0,         0, 32'h0,        32'h00500093, 32'h4,       0);
        row(1, 32'h10,       0, 1, 1, 0, 32'h0,         1, 1, 32'h10,        1, 32'h8,        32'h11111111, 32'hC,       0);
        row(1, 32'h10,       0, 1, 0, 1, 32'h22222222,  1, 0, 32'h0,         1, 32'h8,        32'h11111111, 32'hC,       0);
        row(1, 32'h10,       0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,        32'h11111111, 32'hC,       0);
        row(1, 32'h10,       0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,        32'h11111111, 32'hC,       0);
        row(1, 32'h20,       0, 0, 1, 0, 32'h0,         1, 1, 32'h20,        1, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h20,       1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h100,      0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h100,      0, 0, 0, 1, 32'hDEADBEEF,  1, 0, 32'h0,         0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h100,      0, 0, 1, 0, 32'h0,         1, 1, 32'h100,       0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h100,      1, 0, 0, 1, 32'h33333333,  0, 0, 32'h0,         0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'h6,        0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h10,       32'h22222222, 32'h14,      0);
        row(1, 32'hA,        0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h6,        NOP,          32'hA,       1);
        row(1, 32'hA,        0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h6,        NOP,          32'hA,       1);
        row(1, 32'hFFFFFFFC, 0, 0, 0, 0, 32'h0,         1, 1, 32'hFFFFFFFC,  1, 32'hA,        NOP,          32'hE,       1);
        row(1, 32'hFFFFFFFC, 0, 0, 1, 0, 32'h0,         1, 1, 32'hFFFFFFFC,  0, 32'hA,        NOP,          32'hE,       1);
        row(1, 32'hFFFFFFFC, 0, 0, 0, 1, 32'h44444444,  0, 0, 32'h0,         0, 32'hA,        NOP,          32'hE,       1);
        row(1, 32'h0,        0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFFFFFC, 32'h44444444, 32'h0,       0);
        row(0, 32'h0,        0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFFFFFC, 32'h44444444, 32'h0,       0);
        row(1, 32'h0,        0, 0, 0, 1, 32'h55555555,  1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h0,        0, 0, 0, 1, 32'h66666666,  1, 1, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);
        row(1, 32'h0,        0, 0, 0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,        32'h0,        32'h0,       0);

        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].pc, tbl[i].fl, tbl[i].sid, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            chk($sformatf("vec%0d_stall_pc", i), 32'(stall_pc), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            chk($sformatf("vec%0d_if_pc", i), if_pc, tbl[i].e_ifpc);
            chk($sformatf("vec%0d_if_instr", i), if_instr, tbl[i].e_instr);
            chk($sformatf("vec%0d_if_pc_plus4", i), if_pc_plus4, tbl[i].e_p4);
            chk($sformatf("vec%0d_if_misaligned", i), 32'(if_misaligned), 32'(tbl[i].e_mis));
        end

        // Flush while a response sits in the skid: it must never reach IF/ID.
        drive(1, 32'h40, 0, 0, 1, 0, 32'h0);
        chk("hold_req_valid", 32'(imem_req_valid), 32'h1);
        chk("hold_req_addr", imem_req_addr, 32'h40);
        drive(1, 32'h40, 0, 0, 0, 1, 32'h77777777);
        chk("hold_first_advance", 32'(stall_pc), 32'h0);
        drive(1, 32'h44, 0, 1, 1, 0, 32'h0);
        chk("hold_second_req", 32'(imem_req_valid), 32'h1);
        chk("hold_ifpc_loaded", if_pc, 32'h40);
        drive(1, 32'h44, 0, 1, 0, 1, 32'h88888888);
        chk("hold_skid_stalls_pc", 32'(stall_pc), 32'h1);
        drive(1, 32'h44, 1, 1, 0, 0, 32'h0);
        chk("hold_flush_releases_pc", 32'(stall_pc), 32'h0);
        drive(1, 32'h80, 0, 1, 0, 0, 32'h0);
        chk("hold_flush_clears_if_valid", 32'(if_valid), 32'h0);
        chk("hold_back_in_req", 32'(imem_req_valid), 32'h1);
        chk("hold_new_addr", imem_req_addr, 32'h80);
        chk("hold_skid_not_loaded", if_instr, 32'h77777777);
        drive(1, 32'h80, 0, 0, 0, 0, 32'h0);
        chk("hold_skid_discarded", 32'(if_valid), 32'h0);

        // Randomized run: every pc the program counter steps past must be
        // delivered exactly once, in order, with its memory word or the NOP.
        for (int i = 0; i < int'(N) + 4; i++) begin
            tmp = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 4) == 0) tmp = tmp | 32'($urandom_range(1, 3));
            plist[i] = tmp;
        end
        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        pend = 1'b0; cnt = 0; paddr = '0; k = 0; c = 0;
        for (int cyc = 0; cyc < 4000 && c < int'(N); cyc++) begin
            @(negedge clk);
            reset = 1'b1;
            pc = plist[k];
            flush = 1'b0;
            stall_id = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = 1'b0;
            imem_rsp_data = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            #1;
            tmp = plist[k];
            if (tmp[1:0] != 2'b00) chk("rand_no_req_misaligned", 32'(imem_req_valid), 32'h0);
            if (imem_req_valid) begin
                chk("rand_req_addr", imem_req_addr, plist[k] & 32'hFFFFFFFC);
                chk("rand_single_outstanding", 32'(pend | imem_rsp_valid), 32'h0);
                if (imem_req_ready) begin
                    pend = 1'b1;
                    cnt = $urandom_range(1, 3);
                    paddr = imem_req_addr;
                end
            end
            if (if_valid && !stall_id) begin
                tmp = plist[c];
                e_instr = (tmp[1:0] != 2'b00) ? NOP : mem_word(tmp & 32'hFFFFFFFC);
                chk("rand_if_pc", if_pc, tmp);
                chk("rand_if_instr", if_instr, e_instr);
                chk("rand_if_pc_plus4", if_pc_plus4, tmp + 32'h4);
                chk("rand_if_misaligned", 32'(if_misaligned), 32'(tmp[1:0] != 2'b00));
                c++;
            end
            if (!stall_pc && k < int'(N) + 3) k++;
        end
        checks++;
        if (c < int'(N)) begin
            errors++;
            $display("FAIL rand_budget: delivered %0d required %0d", c, N);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
